// File: rtl/cpu_pkg.sv
// Shared types for the synchronous CPU phase sequencer: control states and phase indices.
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStep,
        StHalted
    } state_e;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

endpackage

// File: rtl/phase_divider.sv
// Phase-length counter: counts div+1 clocks per phase, with div latched at the start of each cycle.
module phase_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             tick_nxt_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign tick_o = (cnt_q == div_q);

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = '0;
            div_d = div_i;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Lets the parent register strobes that line up with the last clock of a phase.
    assign tick_nxt_o = (cnt_d == div_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Single-clock machine-cycle phase generator with run/step/halt control.
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic [DIV_W-1:0] div,
    output logic             cyc_en,
    output logic             cyc_set,
    output logic             set_stb,
    output logic             cyc_end,
    output logic [1:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             step_done,
    output logic [CYC_W-1:0] cycles
);

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;

    logic cyc_en_q, cyc_en_d;
    logic cyc_set_q, cyc_set_d;
    logic set_stb_q, set_stb_d;
    logic cyc_end_q, cyc_end_d;
    logic running_q, running_d;
    logic halted_q, halted_d;
    logic step_done_q, step_done_d;

    logic active, act_d, last_p3, start, adv;
    logic tick, tick_nxt;

    phase_divider #(
        .DIV_W (DIV_W)
    ) u_phase_divider (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (~act_d),
        .load_i     (start),
        .en_i       (adv),
        .div_i      (div),
        .tick_o     (tick),
        .tick_nxt_o (tick_nxt)
    );

    assign active  = (state_q == StRun) || (state_q == StStep);
    assign last_p3 = active && tick && (phase_q == P3);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        halt_pend_d = halt_pend_q;
        start       = 1'b0;
        adv         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StRun;
                    start   = 1'b1;
                end else if (step) begin
                    state_d = StStep;
                    start   = 1'b1;
                end
            end
            StRun, StStep: begin
                adv = 1'b1;
                if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (last_p3) begin
                    // Halt outranks both run-continue and run-drop.
                    if (halt_pend_q || halt) begin
                        state_d = StHalted;
                    end else if (state_q == StRun && run) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHalted: begin
                if (!run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            phase_d = P0;
        end else if (adv && tick) begin
            phase_d = phase_q + 2'd1;
        end

        act_d = (state_d == StRun) || (state_d == StStep);
        if (!act_d) begin
            phase_d     = P0;
            halt_pend_d = 1'b0;
        end
    end

    // Outputs are registered from next-state values so they align with the phase they describe.
    always_comb begin
        cyc_en_d    = act_d && (phase_d != P3);
        cyc_set_d   = act_d && (phase_d == P1);
        set_stb_d   = act_d && (phase_d == P1) && tick_nxt;
        cyc_end_d   = act_d && (phase_d == P3) && tick_nxt;
        step_done_d = (state_d == StStep) && (phase_d == P3) && tick_nxt && !halt_pend_d;
        running_d   = act_d;
        halted_d    = (state_d == StHalted);
        cycles_d    = cycles_q + {{(CYC_W-1){1'b0}}, cyc_end_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= P0;
            halt_pend_q <= 1'b0;
            cycles_q    <= '0;
            cyc_en_q    <= 1'b0;
            cyc_set_q   <= 1'b0;
            set_stb_q   <= 1'b0;
            cyc_end_q   <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            halt_pend_q <= halt_pend_d;
            cycles_q    <= cycles_d;
            cyc_en_q    <= cyc_en_d;
            cyc_set_q   <= cyc_set_d;
            set_stb_q   <= set_stb_d;
            cyc_end_q   <= cyc_end_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            step_done_q <= step_done_d;
        end
    end

    assign cyc_en    = cyc_en_q;
    assign cyc_set   = cyc_set_q;
    assign set_stb   = set_stb_q;
    assign cyc_end   = cyc_end_q;
    assign phase     = phase_q;
    assign running   = running_q;
    assign halted    = halted_q;
    assign step_done = step_done_q;
    assign cycles    = cycles_q;

endmodule
